// File: rtl/mcash_chn_master.sv
// Self-checking traffic initiator for one mcash channel: writes NUM_REQ lines, reads them back with
// up to MAX_OUT reads in flight, checks return data in order; all outputs registered, holds requests under backpressure.
module mcash_chn_master #(
   parameter int          NUM_REQ   = 16,
   parameter int          MAX_OUT   = 4,
   parameter logic [27:0] BASE_ADDR = 28'h0000100,
   parameter logic [31:0] SEED      = 32'hA5A5_0000,
   parameter int          TIMEOUT   = 1024
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         pass_o,
   output logic         timeout_o,
   output logic [15:0]  err_cnt_o,
   output logic         req_valid_o,
   input  logic         req_allowIn_i,
   output logic [2:0]   req_op_o,
   output logic [27:0]  req_addr_o,
   output logic [127:0] req_data_o,
   input  logic         rtn_valid_i,
   output logic         rtn_ready_o,
   input  logic [127:0] rtn_data_i
);

   localparam logic [2:0]  OP_RD    = 3'd0;
   localparam logic [2:0]  OP_WR    = 3'd1;
   localparam logic [15:0] LAST     = 16'(NUM_REQ - 1);
   localparam logic [3:0]  OUT_MAX  = 4'(MAX_OUT);
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [15:0]    idx_q, idx_d;
   logic [15:0]    k_q, k_d;
   logic [3:0]     outs_q, outs_d;
   logic [31:0]    tmo_q, tmo_d;
   logic           valid_d, busy_d, done_d, pass_d, timeout_d;
   logic [2:0]     op_d;
   logic [27:0]    addr_d;
   logic [127:0]   data_d;
   logic [15:0]    err_d;
   logic           err_inc;
   logic           req_hs, rtn_hs, busy_st;

   function automatic logic [127:0] line_data(input logic [15:0] i);
      return {4{SEED ^ {16'h0, i}}};
   endfunction

   function automatic logic [27:0] line_addr(input logic [15:0] i);
      return BASE_ADDR + {12'h0, i};
   endfunction

   assign req_hs  = req_valid_o && req_allowIn_i;
   assign rtn_hs  = rtn_valid_i && rtn_ready_o;
   assign busy_st = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_DRAIN);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      k_d       = k_q;
      outs_d    = outs_q;
      tmo_d     = tmo_q;
      valid_d   = req_valid_o;
      op_d      = req_op_o;
      addr_d    = req_addr_o;
      data_d    = req_data_o;
      timeout_d = timeout_o;
      err_inc   = 1'b0;

      if (req_hs && req_op_o == OP_RD)
         outs_d = outs_d + 4'd1;
      // A return with nothing outstanding is a stray beat: count it, touch nothing else.
      if (rtn_hs) begin
         if (outs_q == 4'd0) begin
            err_inc = 1'b1;
         end else begin
            outs_d = outs_d - 4'd1;
            k_d    = k_q + 16'd1;
            if (rtn_data_i != line_data(k_q))
               err_inc = 1'b1;
         end
      end
      err_d = (err_inc && err_cnt_o != 16'hFFFF) ? err_cnt_o + 16'd1 : err_cnt_o;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d   = S_WR;
               idx_d     = 16'd0;
               k_d       = 16'd0;
               outs_d    = 4'd0;
               err_d     = 16'd0;
               timeout_d = 1'b0;
               valid_d   = 1'b1;
               op_d      = OP_WR;
               addr_d    = BASE_ADDR;
               data_d    = line_data(16'd0);
            end
         end
         S_WR: begin
            if (req_hs) begin
               if (idx_q == LAST) begin
                  // First read goes out on the very next cycle, nothing is in flight yet.
                  state_d = S_RD;
                  idx_d   = 16'd0;
                  valid_d = 1'b1;
                  op_d    = OP_RD;
                  addr_d  = BASE_ADDR;
                  data_d  = '0;
               end else begin
                  idx_d  = idx_q + 16'd1;
                  addr_d = line_addr(idx_q + 16'd1);
                  data_d = line_data(idx_q + 16'd1);
               end
            end
         end
         S_RD: begin
            if (req_hs && idx_q == LAST) begin
               state_d = S_DRAIN;
               valid_d = 1'b0;
            end else begin
               if (req_hs) begin
                  idx_d  = idx_q + 16'd1;
                  addr_d = line_addr(idx_q + 16'd1);
               end
               // Only raise valid when the read is guaranteed a slot; once up it stays up.
               if (req_hs || !req_valid_o)
                  valid_d = (outs_d < OUT_MAX);
            end
         end
         S_DRAIN: begin
            if (outs_q == 4'd0)
               state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (!busy_st || req_hs || rtn_hs || state_d != state_q) begin
         tmo_d = 32'd0;
      end else if (tmo_q == TMO_LAST) begin
         state_d   = S_DONE;
         valid_d   = 1'b0;
         timeout_d = 1'b1;
         tmo_d     = 32'd0;
      end else begin
         tmo_d = tmo_q + 32'd1;
      end

      done_d = (state_d == S_DONE);
      busy_d = (state_d == S_WR) || (state_d == S_RD) || (state_d == S_DRAIN);
      pass_d = done_d && (err_d == 16'd0) && !timeout_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         k_q         <= '0;
         outs_q      <= '0;
         tmo_q       <= '0;
         req_valid_o <= 1'b0;
         req_op_o    <= '0;
         req_addr_o  <= '0;
         req_data_o  <= '0;
         rtn_ready_o <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         timeout_o   <= 1'b0;
         err_cnt_o   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         k_q         <= k_d;
         outs_q      <= outs_d;
         tmo_q       <= tmo_d;
         req_valid_o <= valid_d;
         req_op_o    <= op_d;
         req_addr_o  <= addr_d;
         req_data_o  <= data_d;
         rtn_ready_o <= 1'b1;
         busy_o      <= busy_d;
         done_o      <= done_d;
         pass_o      <= pass_d;
         timeout_o   <= timeout_d;
         err_cnt_o   <= err_d;
      end
   end

endmodule

// File: tb/tb_mcash_chn_master.sv
// Directed bench for mcash_chn_master: responder model on the negedge, immediate-assert checks.
module tb_mcash_chn_master;

   localparam int          NUM  = 16;
   localparam int          MAXO = 4;
   localparam logic [27:0] BASE = 28'hFFFFFFE;
   localparam logic [31:0] SEED = 32'hA5A5_0000;
   localparam int          TMO  = 64;

   logic         clk = 1'b0;
   logic         rst_i, start_i, busy_o, done_o, pass_o, timeout_o;
   logic [15:0]  err_cnt_o;
   logic         req_valid_o, req_allowIn_i, rtn_valid_i, rtn_ready_o;
   logic [2:0]   req_op_o;
   logic [27:0]  req_addr_o;
   logic [127:0] req_data_o, rtn_data_i;

   mcash_chn_master #(
      .NUM_REQ(NUM), .MAX_OUT(MAXO), .BASE_ADDR(BASE), .SEED(SEED), .TIMEOUT(TMO)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .pass_o(pass_o), .timeout_o(timeout_o), .err_cnt_o(err_cnt_o),
      .req_valid_o(req_valid_o), .req_allowIn_i(req_allowIn_i), .req_op_o(req_op_o),
      .req_addr_o(req_addr_o), .req_data_o(req_data_o), .rtn_valid_i(rtn_valid_i),
      .rtn_ready_o(rtn_ready_o), .rtn_data_i(rtn_data_i)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0, wr_cnt, rd_cnt, ret_cnt, b_out, max_seen;
   int first_hs, last_hs_cyc, last_ret_cyc, done_cyc;
   int allow_mode = 0, lat = 2;
   logic ret_en = 1'b1, stray_now = 1'b0, stray_drain = 1'b0, prev_stall = 1'b0;
   logic [15:0]  corrupt = '0;
   logic [159:0] prev_fields;
   logic [27:0]  wr_log [4];
   logic [127:0] mem [logic [27:0]];
   int           q_due[$];
   logic [27:0]  q_addr[$];
   int           q_idx[$];

   function automatic logic [127:0] pat(input int i);
      logic [31:0] iv;
      logic [31:0] w;
      iv = i;
      w  = SEED ^ {16'h0, iv[15:0]};
      return {4{w}};
   endfunction

   function automatic logic [27:0] exp_addr(input int i);
      return BASE + 28'(i);
   endfunction

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: observe registered outputs, play the cache side for the coming edge.
   task automatic cycle();
      logic [127:0] d;
      @(negedge clk);
      if (prev_stall)
         chk("stall_hold", 192'({req_valid_o, req_op_o, req_addr_o, req_data_o}), 192'(prev_fields));
      req_allowIn_i = (allow_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      prev_stall  = req_valid_o && !req_allowIn_i;
      prev_fields = {req_valid_o, req_op_o, req_addr_o, req_data_o};
      if (req_valid_o && req_allowIn_i) begin
         if (first_hs < 0) first_hs = cyc;
         last_hs_cyc = cyc;
         if (req_op_o == 3'd1) begin
            chk("wr_addr", 192'(req_addr_o), 192'(exp_addr(wr_cnt)));
            chk("wr_data", 192'(req_data_o), 192'(pat(wr_cnt)));
            if (wr_cnt < 4) wr_log[wr_cnt] = req_addr_o;
            mem[req_addr_o] = req_data_o;
            wr_cnt++;
         end else begin
            chk("rd_op", 192'(req_op_o), 192'(0));
            chk("rd_addr", 192'(req_addr_o), 192'(exp_addr(rd_cnt)));
            chk("rd_data_zero", 192'(req_data_o), 192'(0));
            q_due.push_back(cyc + lat);
            q_addr.push_back(req_addr_o);
            q_idx.push_back(rd_cnt);
            rd_cnt++;
            b_out++;
         end
      end
      rtn_valid_i = 1'b0;
      rtn_data_i  = '0;
      if (stray_now) begin
         rtn_valid_i = 1'b1;
         rtn_data_i  = '1;
         stray_now   = 1'b0;
      end else if (ret_en && q_due.size() > 0 && rtn_ready_o) begin
         if (q_due[0] <= cyc) begin
            d = mem.exists(q_addr[0]) ? mem[q_addr[0]] : '0;
            if (corrupt[q_idx[0]]) d[0] = ~d[0];
            rtn_valid_i = 1'b1;
            rtn_data_i  = d;
            void'(q_due.pop_front());
            void'(q_addr.pop_front());
            void'(q_idx.pop_front());
            b_out--;
            ret_cnt++;
            last_ret_cyc = cyc;
            if (ret_cnt == NUM && stray_drain) begin
               stray_now   = 1'b1;
               stray_drain = 1'b0;
            end
         end
      end
      if (b_out > max_seen) max_seen = b_out;
      cyc++;
   endtask

   task automatic begin_run();
      wr_cnt = 0; rd_cnt = 0; ret_cnt = 0; b_out = 0; max_seen = 0; first_hs = -1;
      prev_stall = 1'b0;
      q_due.delete(); q_addr.delete(); q_idx.delete(); mem.delete();
      start_i = 1'b1;
      cycle();
      start_i = 1'b0;
      chk("start_flags", 192'({busy_o, done_o, pass_o, timeout_o, req_valid_o, req_op_o}), 192'(8'b1000_1001));
      chk("start_err_clr", 192'(err_cnt_o), 192'(0));
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done_o && n < budget) begin
         cycle();
         n++;
      end
      done_cyc = cyc - 1;
      chk("run_done", 192'(done_o), 192'(1));
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; req_allowIn_i = 1'b0; rtn_valid_i = 1'b0; rtn_data_i = '0;
      repeat (3) @(negedge clk);
      chk("reset_state", 192'({busy_o, done_o, pass_o, timeout_o, err_cnt_o, req_valid_o, req_op_o,
                               req_addr_o, req_data_o, rtn_ready_o}), 192'(0));
      rst_i = 1'b0;
      cycle();
      chk("rtn_ready_up", 192'(rtn_ready_o), 192'(1));

      // Stray return while idle
      stray_now = 1'b1;
      cycle();
      cycle();
      chk("idle_stray_err", 192'(err_cnt_o), 192'(1));
      chk("idle_stray_state", 192'({busy_o, done_o}), 192'(0));

      // Ideal responder
      allow_mode = 0; lat = 2; ret_en = 1'b1; corrupt = '0;
      begin_run();
      wait_done(200);
      chk("ideal_flags", 192'({pass_o, timeout_o, busy_o}), 192'(3'b100));
      chk("ideal_err", 192'(err_cnt_o), 192'(0));
      chk("ideal_wr_cnt", 192'(wr_cnt), 192'(16));
      chk("ideal_rd_cnt", 192'(rd_cnt), 192'(16));
      chk("ideal_span", 192'(last_hs_cyc - first_hs + 1), 192'(32));
      chk("ideal_done_lag", 192'(done_cyc - last_ret_cyc), 192'(2));
      chk("wrap_a0", 192'(wr_log[0]), 192'(28'hFFFFFFE));
      chk("wrap_a1", 192'(wr_log[1]), 192'(28'hFFFFFFF));
      chk("wrap_a2", 192'(wr_log[2]), 192'(28'h0000000));
      chk("wrap_a3", 192'(wr_log[3]), 192'(28'h0000001));

      // Backpressure: allowIn 1-of-3, returns 10 cycles late
      allow_mode = 1; lat = 10;
      begin_run();
      wait_done(600);
      chk("bp_flags", 192'({pass_o, timeout_o}), 192'(2'b10));
      chk("bp_err", 192'(err_cnt_o), 192'(0));
      chk("bp_max_out", 192'(max_seen), 192'(4));
      chk("bp_rd_cnt", 192'(rd_cnt), 192'(16));

      // Corrupted lines 3 and 7
      allow_mode = 0; lat = 2; corrupt = 16'h0088;
      begin_run();
      wait_done(200);
      chk("corrupt_err", 192'(err_cnt_o), 192'(2));
      chk("corrupt_flags", 192'({done_o, pass_o, timeout_o}), 192'(3'b100));
      corrupt = '0;

      // Stray beat in DRAIN after the last return
      stray_drain = 1'b1;
      begin_run();
      wait_done(200);
      chk("drain_stray_err", 192'(err_cnt_o), 192'(1));
      chk("drain_stray_flags", 192'({pass_o, timeout_o}), 192'(0));

      // Responder never returns reads
      ret_en = 1'b0;
      begin_run();
      wait_done(300);
      chk("tmo_flags", 192'({done_o, timeout_o, pass_o, busy_o, req_valid_o}), 192'(5'b11000));
      chk("tmo_wr_cnt", 192'(wr_cnt), 192'(16));
      chk("tmo_rd_cnt", 192'(rd_cnt), 192'(4));
      chk("tmo_lag", 192'(done_cyc - last_hs_cyc), 192'(65));
      ret_en = 1'b1;

      // Reset in the middle of the read phase, then a clean run
      begin_run();
      for (int n = 0; n < 100 && rd_cnt < 6; n++) cycle();
      chk("mid_rd_reached", 192'({busy_o, 32'(rd_cnt)}), 192'({1'b1, 32'd6}));
      rst_i = 1'b1; req_allowIn_i = 1'b0; rtn_valid_i = 1'b0; rtn_data_i = '0;
      @(negedge clk);
      chk("mid_rd_reset", 192'({busy_o, done_o, pass_o, timeout_o, err_cnt_o, req_valid_o, req_op_o,
                                req_addr_o, req_data_o, rtn_ready_o}), 192'(0));
      rst_i = 1'b0;
      prev_stall = 1'b0;
      begin_run();
      wait_done(200);
      chk("post_reset_pass", 192'({pass_o, timeout_o}), 192'(2'b10));
      chk("post_reset_err", 192'(err_cnt_o), 192'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
